// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps a 3-input gate through all rows, majority-votes its
// output per row and compares the assembled 8-bit code against EXPECTED.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SAMPLES       = 3,
    parameter logic [7:0]  EXPECTED      = 8'hC5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    output logic [2:0] in_vec_o,
    input  logic       dut_out_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] table_o,
    output logic       pass_o
);

    localparam int unsigned CMAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int unsigned OW   = $clog2(SAMPLES + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES - 1);
    localparam logic [OW-1:0] HALF        = OW'(SAMPLES / 2);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      row_q;
    logic [OW-1:0]   ones_q;
    logic [OW-1:0]   ones_d;
    logic [2:0]      in_vec_q;
    logic            busy_q;
    logic            done_q;
    logic [7:0]      table_q;
    logic [7:0]      table_d;
    logic            pass_q;

    // Row r lands in bit 7-r, i.e. the bitwise inverse of the row index.
    always_comb begin
        ones_d           = ones_q + OW'(dut_out_i);
        table_d          = table_q;
        table_d[~row_q]  = (ones_d > HALF);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            row_q    <= '0;
            ones_q   <= '0;
            in_vec_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            table_q  <= '0;
            pass_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && (state_q == SETTLE || state_q == SAMPLE)) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                row_q    <= '0;
                ones_q   <= '0;
                in_vec_q <= '0;
                busy_q   <= 1'b0;
                table_q  <= '0;
                pass_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i && !abort_i) begin
                            state_q  <= SETTLE;
                            cnt_q    <= '0;
                            row_q    <= '0;
                            ones_q   <= '0;
                            in_vec_q <= '0;
                            busy_q   <= 1'b1;
                            table_q  <= '0;
                            pass_q   <= 1'b0;
                        end
                    end
                    SETTLE: begin
                        if (cnt_q == SETTLE_LAST) begin
                            cnt_q   <= '0;
                            state_q <= SAMPLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    SAMPLE: begin
                        if (cnt_q == SAMPLE_LAST) begin
                            cnt_q   <= '0;
                            ones_q  <= '0;
                            table_q <= table_d;
                            if (row_q != 3'd7) begin
                                row_q    <= row_q + 3'd1;
                                in_vec_q <= row_q + 3'd1;
                                state_q  <= SETTLE;
                            end else begin
                                row_q    <= '0;
                                in_vec_q <= '0;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                pass_q   <= (table_d == EXPECTED);
                                state_q  <= FINISH;
                            end
                        end else begin
                            ones_q <= ones_d;
                            cnt_q  <= cnt_q + 1'b1;
                        end
                    end
                    FINISH: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign in_vec_o = in_vec_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign table_o  = table_q;
    assign pass_o   = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboarded bench for truth_table_sweeper with a behavioural 0xC5 gate that
// can be tied low or have trailing row-2 samples inverted.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       dut_out;
    logic [2:0] in_vec;
    logic       busy;
    logic       done;
    logic [7:0] tbl;
    logic       pass;

    truth_table_sweeper #(
        .SETTLE_CYCLES(4),
        .SAMPLES      (3),
        .EXPECTED     (8'hC5)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .abort_i  (abort),
        .in_vec_o (in_vec),
        .dut_out_i(dut_out),
        .busy_o   (busy),
        .done_o   (done),
        .table_o  (tbl),
        .pass_o   (pass)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  t;
        logic        p;
        logic [31:0] c;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   ndone = 0;

    // Gate model: row r drives bit 7-r of the code; the last fault_k sample
    // cycles of row 2 are inverted.
    logic [7:0] gate = 8'hC5;
    bit         tie0 = 1'b0;
    int         fault_k = 0;
    logic [2:0] last_vec = 3'd0;
    int         age = 0;

    always @(negedge clk) begin
        if (in_vec != last_vec) begin
            age      = 0;
            last_vec = in_vec;
        end else begin
            age = age + 1;
        end
    end

    assign dut_out = tie0 ? 1'b0
                   : (gate[~in_vec] ^ ((in_vec == 3'd2) && (fault_k > 0) && (age >= 7 - fault_k)));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            ndone++;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                e = sbq.pop_front();
                chk("table", 32'(tbl), 32'(e.t));
                chk("pass", 32'(pass), 32'(e.p));
                chk("done_latency", 32'(cyc - e.c), 32'd56);
            end
        end
    end

    task automatic sweep(input logic [7:0] et, input logic ep, input bit t6,
                         input int abort_at, input int rst_at);
        int d0;
        d0 = ndone;
        if (abort_at < 0 && rst_at < 0)
            sbq.push_back(exp_t'{t: et, p: ep, c: 32'(cyc + 1)});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 56; i++) begin
            if (t6) begin
                chk("in_vec_step", 32'(in_vec), 32'(i / 7));
                chk("busy_during_sweep", 32'(busy), 32'd1);
                start = (i == 10 || i == 20);
            end
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_in_vec", 32'(in_vec), 32'd0);
                chk("abort_table", 32'(tbl), 32'd0);
                chk("abort_pass", 32'(pass), 32'd0);
                repeat (4) @(negedge clk);
                chk("abort_no_done", 32'(ndone - d0), 32'd0);
                return;
            end
            if (i == rst_at) begin
                #1 rst = 1'b1;
                #1;
                chk("async_rst_busy", 32'(busy), 32'd0);
                chk("async_rst_in_vec", 32'(in_vec), 32'd0);
                chk("async_rst_table", 32'(tbl), 32'd0);
                chk("async_rst_pass", 32'(pass), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                chk("rst_no_done", 32'(ndone - d0), 32'd0);
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("single_done", 32'(ndone - d0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_table", 32'(tbl), 32'd0);
        chk("reset_pass", 32'(pass), 32'd0);
        chk("reset_in_vec", 32'(in_vec), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal 0xC5 gate
        sweep(8'hC5, 1'b1, 1'b0, -1, -1);
        repeat (3) @(negedge clk);
        chk("hold_table", 32'(tbl), 32'hC5);
        chk("hold_pass", 32'(pass), 32'd1);
        chk("idle_in_vec", 32'(in_vec), 32'd0);

        // Gate tied low
        tie0 = 1'b1;
        sweep(8'h00, 1'b0, 1'b0, -1, -1);
        tie0 = 1'b0;

        // One then two disturbed samples in row 2
        fault_k = 1;
        sweep(8'hC5, 1'b1, 1'b0, -1, -1);
        fault_k = 2;
        sweep(8'hE5, 1'b0, 1'b0, -1, -1);
        fault_k = 0;

        // Abort in row 4 SETTLE, then restart
        sweep(8'h00, 1'b0, 1'b0, 29, -1);
        sweep(8'hC5, 1'b1, 1'b0, -1, -1);

        // start together with abort in IDLE is refused
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("start_abort_idle_in_vec", 32'(in_vec), 32'd0);

        // Asynchronous reset mid-SAMPLE of row 2, then full sweep
        sweep(8'h00, 1'b0, 1'b0, -1, 19);
        sweep(8'hC5, 1'b1, 1'b0, -1, -1);

        // Start pulses while busy, in_vec stepping checked every cycle
        sweep(8'hC5, 1'b1, 1'b1, -1, -1);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
